// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: game FSM, score registers, serve/point timers.
// Gates ball motion and declares the winner at WIN_SCORE.
module pong_match_ctrl #(
  parameter int WIN_SCORE    = 9,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       start_ball,
  input  logic       frame_tick,
  input  logic       score1,
  input  logic       score2,
  output logic       ball_run,
  output logic       ball_home,
  output logic       serve_dir,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic [1:0] winner,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_SERVE = 3'd2,
    S_PLAY  = 3'd3,
    S_POINT = 3'd4,
    S_OVER  = 3'd5
  } state_t;

  localparam logic [3:0] LP_WIN   = 4'(WIN_SCORE);
  localparam logic [7:0] LP_SERVE = 8'(SERVE_FRAMES);
  localparam logic [7:0] LP_POINT = 8'(POINT_FRAMES);

  state_t     r_state;
  state_t     w_state_nx;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_nx;
  logic [3:0] r_p1;
  logic [3:0] r_p2;
  logic [3:0] w_p1_nx;
  logic [3:0] w_p2_nx;
  logic [3:0] w_p1_inc;
  logic [3:0] w_p2_inc;
  logic [1:0] r_win;
  logic [1:0] w_win_nx;
  logic       r_dir;
  logic       w_dir_nx;
  logic       r_run;
  logic       r_home;

  logic       r_st_cur;
  logic       r_st_prev;
  logic       r_st_rise;
  logic       r_sb_cur;
  logic       r_sb_prev;
  logic       r_sb_rise;
  logic       w_st_rise;
  logic       w_sb_rise;

  assign w_st_rise = r_st_cur & ~r_st_prev;
  assign w_sb_rise = r_sb_cur & ~r_sb_prev;
  assign w_p1_inc  = r_p1 + 4'd1;
  assign w_p2_inc  = r_p2 + 4'd1;

  // Sample the button levels and register their rising edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_st_cur  <= 1'b0;
      r_st_prev <= 1'b0;
      r_st_rise <= 1'b0;
      r_sb_cur  <= 1'b0;
      r_sb_prev <= 1'b0;
      r_sb_rise <= 1'b0;
    end else begin
      r_st_cur  <= start;
      r_st_prev <= r_st_cur;
      r_st_rise <= w_st_rise;
      r_sb_cur  <= start_ball;
      r_sb_prev <= r_sb_cur;
      r_sb_rise <= w_sb_rise;
    end
  end

  // Next-state, timer and score update for the match FSM.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_p1_nx    = r_p1;
    w_p2_nx    = r_p2;
    w_win_nx   = r_win;
    w_dir_nx   = r_dir;
    unique case (r_state)
      S_IDLE, S_OVER: begin
        if (r_st_rise) begin
          w_p1_nx    = 4'd0;
          w_p2_nx    = 4'd0;
          w_win_nx   = 2'b00;
          w_dir_nx   = 1'b0;
          w_state_nx = S_ARMED;
        end
      end
      S_ARMED: begin
        if (r_sb_rise) begin
          w_cnt_nx   = LP_SERVE;
          w_state_nx = S_SERVE;
        end
      end
      S_SERVE: begin
        if (frame_tick) begin
          w_cnt_nx = r_cnt - 8'd1;
          if (r_cnt == 8'd1) begin
            w_state_nx = S_PLAY;
          end
        end
      end
      S_PLAY: begin
        if (score1 && !score2) begin
          w_p1_nx  = w_p1_inc;
          w_dir_nx = 1'b1;
          if (w_p1_inc == LP_WIN) begin
            w_win_nx   = 2'b01;
            w_state_nx = S_OVER;
          end else begin
            w_cnt_nx   = LP_POINT;
            w_state_nx = S_POINT;
          end
        end else if (score2 && !score1) begin
          w_p2_nx  = w_p2_inc;
          w_dir_nx = 1'b0;
          if (w_p2_inc == LP_WIN) begin
            w_win_nx   = 2'b10;
            w_state_nx = S_OVER;
          end else begin
            w_cnt_nx   = LP_POINT;
            w_state_nx = S_POINT;
          end
        end
      end
      S_POINT: begin
        if (frame_tick) begin
          w_cnt_nx = r_cnt - 8'd1;
          if (r_cnt == 8'd1) begin
            w_state_nx = S_ARMED;
          end
        end
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // Register state, timer, scores and the ball gating outputs together.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
      r_p1    <= 4'd0;
      r_p2    <= 4'd0;
      r_win   <= 2'b00;
      r_dir   <= 1'b0;
      r_run   <= 1'b0;
      r_home  <= 1'b1;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_p1    <= w_p1_nx;
      r_p2    <= w_p2_nx;
      r_win   <= w_win_nx;
      r_dir   <= w_dir_nx;
      r_run   <= (w_state_nx == S_PLAY);
      r_home  <= (w_state_nx != S_PLAY);
    end
  end

  assign ball_run  = r_run;
  assign ball_home = r_home;
  assign serve_dir = r_dir;
  assign p1_score  = r_p1;
  assign p2_score  = r_p2;
  assign winner    = r_win;
  assign state_o   = r_state;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Bench for pong_match_ctrl: directed scenarios plus random
// stimulus against a frame/edge-level model of the match rules.
module tb_pong_match_ctrl;

  localparam int WIN = 3;
  localparam int SF  = 3;
  localparam int PF  = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       start_ball = 1'b0;
  logic       frame_tick = 1'b0;
  logic       score1 = 1'b0;
  logic       score2 = 1'b0;
  logic       ball_run;
  logic       ball_home;
  logic       serve_dir;
  logic [3:0] p1_score;
  logic [3:0] p2_score;
  logic [1:0] winner;
  logic [2:0] state_o;

  int checks = 0;
  int failures = 0;

  pong_match_ctrl #(
    .WIN_SCORE(WIN), .SERVE_FRAMES(SF), .POINT_FRAMES(PF)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .start_ball(start_ball), .frame_tick(frame_tick),
    .score1(score1), .score2(score2),
    .ball_run(ball_run), .ball_home(ball_home),
    .serve_dir(serve_dir), .p1_score(p1_score),
    .p2_score(p2_score), .winner(winner), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Reference model. States: 0 idle,1 armed,2 serve,3 play,4 point,5 over
  int m_st, m_p1, m_p2, m_win, m_dir, m_cnt;
  bit hs[3];
  bit hb[3];
  bit m_rs, m_rb;

  always @(posedge clk) begin
    if (reset) begin
      m_st = 0; m_p1 = 0; m_p2 = 0; m_win = 0; m_dir = 0; m_cnt = 0;
      hs = '{0, 0, 0};
      hb = '{0, 0, 0};
    end else begin
      // a level first sampled at edge k acts at edge k+2
      m_rs = hs[1] && !hs[2];
      m_rb = hb[1] && !hb[2];
      case (m_st)
        0, 5: if (m_rs) begin
          m_p1 = 0; m_p2 = 0; m_win = 0; m_dir = 0; m_st = 1;
        end
        1: if (m_rb) begin
          m_cnt = SF; m_st = 2;
        end
        2: if (frame_tick) begin
          m_cnt = m_cnt - 1;
          if (m_cnt == 0) m_st = 3;
        end
        3: if (score1 != score2) begin
          if (score1) begin m_p1++; m_dir = 1; end
          else begin m_p2++; m_dir = 0; end
          if (m_p1 == WIN) begin m_win = 1; m_st = 5; end
          else if (m_p2 == WIN) begin m_win = 2; m_st = 5; end
          else begin m_cnt = PF; m_st = 4; end
        end
        4: if (frame_tick) begin
          m_cnt = m_cnt - 1;
          if (m_cnt == 0) m_st = 1;
        end
        default: ;
      endcase
      hs[2] = hs[1]; hs[1] = hs[0]; hs[0] = start;
      hb[2] = hb[1]; hb[1] = hb[0]; hb[0] = start_ball;
    end
  end

  function automatic logic [15:0] exp_vec();
    return {3'(m_st), m_st == 3, m_st != 3, 1'(m_dir),
            4'(m_p1), 4'(m_p2), 2'(m_win)};
  endfunction

  function automatic logic [15:0] dut_vec();
    return {state_o, ball_run, ball_home, serve_dir,
            p1_score, p2_score, winner};
  endfunction

  localparam logic [15:0] RST_VEC = 16'b000_0_1_0_0000_0000_00;

  task automatic clkn(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic s1, input logic s2);
    score1 = s1; score2 = s2;
    clkn(1);
    score1 = 1'b0; score2 = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      frame_tick = 1'b1; clkn(1);
      frame_tick = 1'b0; clkn(1);
    end
  endtask

  task automatic serve_to_play();
    start_ball = 1'b0; clkn(1);
    start_ball = 1'b1; clkn(3);
    start_ball = 1'b0;
    ticks(SF);
  endtask

  task automatic test_reset();
    reset = 1'b1; clkn(2);
    checks++;
    if (dut_vec() !== RST_VEC) begin
      failures++;
      $display("FAIL reset_vec got=%h want=%h", dut_vec(), RST_VEC);
    end
    reset = 1'b0; clkn(1);
    checks++;
    if (dut_vec() !== RST_VEC) begin
      failures++;
      $display("FAIL reset_hold got=%h want=%h", dut_vec(), RST_VEC);
    end
  endtask

  task automatic test_serve();
    start = 1'b1; clkn(2);
    checks++;
    if (state_o !== 3'd0) begin
      failures++;
      $display("FAIL start_latency_early got=%0d want=0", state_o);
    end
    clkn(1);
    checks++;
    if (state_o !== 3'd1 || ball_home !== 1'b1) begin
      failures++;
      $display("FAIL armed got=%0d/%b want=1/1", state_o, ball_home);
    end
    start = 1'b0;
    start_ball = 1'b1; clkn(2);
    frame_tick = 1'b1; clkn(1);
    frame_tick = 1'b0;
    checks++;
    if (state_o !== 3'd2 || ball_run !== 1'b0) begin
      failures++;
      $display("FAIL serve_entry got=%0d/%b want=2/0", state_o, ball_run);
    end
    start_ball = 1'b0;
    for (int i = 0; i < SF; i++) begin
      frame_tick = 1'b1; clkn(1);
      frame_tick = 1'b0;
      checks++;
      if (i < SF - 1) begin
        if (state_o !== 3'd2 || ball_run !== 1'b0) begin
          failures++;
          $display("FAIL serve_count tick=%0d got=%0d/%b want=2/0",
                   i, state_o, ball_run);
        end
      end else if (state_o !== 3'd3 || ball_run !== 1'b1
                   || ball_home !== 1'b0) begin
        failures++;
        $display("FAIL serve_release got=%0d/%b/%b want=3/1/0",
                 state_o, ball_run, ball_home);
      end
      clkn(1);
    end
  endtask

  task automatic test_point();
    pulse(1'b0, 1'b1);
    checks++;
    if (p2_score !== 4'd1 || serve_dir !== 1'b0 || state_o !== 3'd4) begin
      failures++;
      $display("FAIL point_p2 got=%0d/%b/%0d want=1/0/4",
               p2_score, serve_dir, state_o);
    end
    pulse(1'b1, 1'b0);
    checks++;
    if (p1_score !== 4'd0 || state_o !== 3'd4) begin
      failures++;
      $display("FAIL point_ignore got=%0d/%0d want=0/4", p1_score, state_o);
    end
    ticks(1);
    checks++;
    if (state_o !== 3'd4) begin
      failures++;
      $display("FAIL point_len got=%0d want=4", state_o);
    end
    ticks(1);
    checks++;
    if (state_o !== 3'd1) begin
      failures++;
      $display("FAIL point_end got=%0d want=1", state_o);
    end
    clkn(5);
    checks++;
    if (state_o !== 3'd1) begin
      failures++;
      $display("FAIL need_rise got=%0d want=1", state_o);
    end
    serve_to_play();
    checks++;
    if (state_o !== 3'd3) begin
      failures++;
      $display("FAIL reserve got=%0d want=3", state_o);
    end
  endtask

  task automatic test_win();
    for (int k = 1; k <= WIN; k++) begin
      pulse(1'b1, 1'b0);
      if (k < WIN) begin
        checks++;
        if (p1_score !== 4'(k) || serve_dir !== 1'b1 || state_o !== 3'd4)
        begin
          failures++;
          $display("FAIL win_step k=%0d got=%0d/%b/%0d want=%0d/1/4",
                   k, p1_score, serve_dir, state_o, k);
        end
        ticks(PF);
        serve_to_play();
      end
    end
    checks++;
    if (p1_score !== 4'd3 || winner !== 2'b01 || state_o !== 3'd5
        || ball_run !== 1'b0) begin
      failures++;
      $display("FAIL win_over got=%0d/%b/%0d/%b want=3/01/5/0",
               p1_score, winner, state_o, ball_run);
    end
    pulse(1'b1, 1'b0);
    checks++;
    if (p1_score !== 4'd3 || winner !== 2'b01) begin
      failures++;
      $display("FAIL win_hold got=%0d/%b want=3/01", p1_score, winner);
    end
    start = 1'b1; clkn(3);
    start = 1'b0;
    checks++;
    if (state_o !== 3'd1 || p1_score !== 4'd0 || p2_score !== 4'd0
        || winner !== 2'b00 || serve_dir !== 1'b0) begin
      failures++;
      $display("FAIL restart got=%h want_state=1_scores=0", dut_vec());
    end
  endtask

  task automatic test_simul();
    serve_to_play();
    pulse(1'b1, 1'b1);
    checks++;
    if (p1_score !== 4'd0 || p2_score !== 4'd0 || state_o !== 3'd3) begin
      failures++;
      $display("FAIL simul got=%0d/%0d/%0d want=0/0/3",
               p1_score, p2_score, state_o);
    end
    start = 1'b1; clkn(4);
    start = 1'b0;
    checks++;
    if (state_o !== 3'd3) begin
      failures++;
      $display("FAIL start_in_play got=%0d want=3", state_o);
    end
  endtask

  task automatic test_ignored();
    reset = 1'b1; clkn(1);
    reset = 1'b0;
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    checks++;
    if (state_o !== 3'd0 || p1_score !== 4'd0 || p2_score !== 4'd0) begin
      failures++;
      $display("FAIL idle_score got=%h want_idle_zero", dut_vec());
    end
    start = 1'b1; clkn(3);
    start = 1'b0;
    start_ball = 1'b1; clkn(3);
    ticks(SF);
    pulse(1'b0, 1'b1);
    ticks(PF);
    clkn(4);
    checks++;
    if (state_o !== 3'd1 || p2_score !== 4'd1) begin
      failures++;
      $display("FAIL held_ball got=%0d/%0d want=1/1", state_o, p2_score);
    end
    start_ball = 1'b0; clkn(1);
    start_ball = 1'b1; clkn(3);
    pulse(1'b1, 1'b0);
    checks++;
    if (state_o !== 3'd2 || p1_score !== 4'd0) begin
      failures++;
      $display("FAIL serve_score got=%0d/%0d want=2/0", state_o, p1_score);
    end
    ticks(1);
    reset = 1'b1; clkn(1);
    checks++;
    if (dut_vec() !== RST_VEC) begin
      failures++;
      $display("FAIL reset_mid_serve got=%h want=%h", dut_vec(), RST_VEC);
    end
    reset = 1'b0;
    start_ball = 1'b0;
    clkn(1);
  endtask

  task automatic test_random();
    reset = 1'b1; clkn(1);
    reset = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL random cyc=%0d got=%h want=%h",
                 c, dut_vec(), exp_vec());
      end
      frame_tick = ($urandom % 3) == 0;
      score1     = ($urandom % 10) == 0;
      score2     = ($urandom % 10) == 0;
      if (($urandom % 12) == 0) start = ~start;
      if (($urandom % 6) == 0) start_ball = ~start_ball;
      reset = ($urandom % 500) == 0;
      clkn(1);
    end
    reset = 1'b0; frame_tick = 1'b0;
    score1 = 1'b0; score2 = 1'b0;
  endtask

  initial begin
    clkn(1);
    test_reset();
    test_serve();
    test_point();
    test_win();
    test_simul();
    test_ignored();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pong_match_ctrl.md
# pong_match_ctrl

Match sequencer for the two-bar Pong game. It sits between the animation generator and the seven-segment score display. It owns the game-level state machine (idle, serve countdown, rally, point freeze, game over) and the per-player score registers. It gates ball motion through `ball_run`/`ball_home`, counts frame ticks from the VGA sync module for timed pauses, and declares a winner at a configurable score.

## Interface
- `WIN_SCORE`, default 9: score that ends the match (1..15).
- `SERVE_FRAMES`, default 60: frames of countdown before the ball is released (1..255).
- `POINT_FRAMES`, default 90: frames of freeze after a point (1..255).
- `clk`  in  1: 50 MHz system clock (`clk_50` domain). One clock.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: level from a debounced button; only the rising edge is used.
- `start_ball`  in  1: level; only the rising edge is used; launches the serve.
- `frame_tick`  in  1: one-cycle pulse per video frame, from the sync module.
- `score1`  in  1: one-cycle pulse; player 1 (top bar) scored.
- `score2`  in  1: one-cycle pulse; player 2 (bottom bar) scored.
- `ball_run`  out  1: ball may move.
- `ball_home`  out  1: hold the ball at the centre position.
- `serve_dir`  out  1: 0 = serve toward player 1, 1 = serve toward player 2.
- `p1_score`  out  4: player 1 score, binary.
- `p2_score`  out  4: player 2 score, binary.
- `winner`  out  2: 00 none, 01 player 1, 10 player 2.
- `state_o`  out  3: encoded state for debug/LEDs: IDLE=0, ARMED=1, SERVE=2, PLAY=3, POINT=4, OVER=5.

## Operation
- Edge detection: `start` and `start_ball` are registered each cycle. A rise is current=1 while previous=0. Both registers clear on reset.
- **IDLE**
  - Outputs: `ball_home`=1, `ball_run`=0.
  - A `start` rise clears both scores, `winner`, and `serve_dir`, then goes to ARMED.
- **ARMED**
  - Outputs: `ball_home`=1, `ball_run`=0.
  - A `start_ball` rise loads the frame counter with `SERVE_FRAMES` and goes to SERVE.
- **SERVE**
  - Outputs: `ball_home`=1, `ball_run`=0.
  - Each `frame_tick` decrements the counter. On the tick that brings it to 0, go to PLAY.
- **PLAY**
  - Outputs: `ball_home`=0, `ball_run`=1.
  - `score1` alone: increment `p1_score`, set `serve_dir`=1 (the loser receives the serve).
  - `score2` alone: increment `p2_score`, set `serve_dir`=0.
  - After either single point:
    - if the new score equals `WIN_SCORE`, set `winner` and go to OVER;
    - otherwise load the counter with `POINT_FRAMES` and go to POINT.
  - `score1` and `score2` asserted in the same cycle: both pulses are ignored and the state stays PLAY.
- **POINT**
  - Outputs: `ball_run`=0, `ball_home`=1.
  - Counts down on `frame_tick`; at 0, goes to ARMED. The next serve needs a fresh `start_ball` rise.
- **OVER**
  - Outputs: `ball_run`=0, `ball_home`=1. Scores and `winner` are held.
  - A `start` rise acts as in IDLE and starts a new match directly.
- `start` rises in ARMED, SERVE, PLAY, or POINT are ignored; there is no mid-match restart except through `reset`.
- Score pulses outside PLAY are ignored.
- Scores never exceed `WIN_SCORE`, so no wrap-around exists. Increment logic is 4-bit unsigned.
- `frame_tick` coinciding with a state entry does not count. Counting starts on the cycle after the load.

## Timing
- Reset values: state IDLE, `ball_run`=0, `ball_home`=1, `serve_dir`=0, `p1_score`=0, `p2_score`=0, `winner`=00, counter 0.
- Reset wins over every other input in the same cycle, including mid-countdown and mid-rally.
- All outputs are registered.
- `state_o`, `ball_run`, `ball_home` follow the state register and change on the same edge as the state.
- Edge latency:
  - input rise at edge N is seen at edge N+1 (detect);
  - the state changes at edge N+2.
- Score pulse latency:
  - a pulse sampled at edge N updates the score and `winner` at edge N (same edge);
  - `state_o` shows POINT/OVER from edge N.
- SERVE length is exactly `SERVE_FRAMES` frame ticks; POINT length is exactly `POINT_FRAMES`.
- Both counters are 8-bit.

## Test plan
- Reset sequence:
  - Stimulus: assert `reset` for 2 cycles.
  - Required: all outputs at their reset values; `state_o`=0.
- Serve countdown (`SERVE_FRAMES`=3):
  - Stimulus: `start` rise, then `start_ball` rise.
  - Required: `state_o`=2; `ball_run` rises exactly on the edge of the 3rd `frame_tick` after entry.
- Point flow (`POINT_FRAMES`=2):
  - Stimulus: in PLAY, pulse `score2`.
  - Required: `p2_score`=1, `serve_dir`=0, `state_o`=4.
  - Then 2 ticks later `state_o`=1; a new `start_ball` rise is required to serve.
- Win (`WIN_SCORE`=3):
  - Stimulus: 3 `score1` points.
  - Required: `p1_score`=3, `winner`=01, `state_o`=5; a further `score1` leaves `p1_score` at 3.
  - Then a `start` rise clears the scores and moves to ARMED.
- Simultaneous pulses:
  - Stimulus: `score1` and `score2` in the same cycle during PLAY.
  - Required: both scores unchanged, `state_o` stays 3.
- Ignored inputs:
  - Stimulus: score pulses in IDLE/SERVE/POINT, `start` rise in PLAY, held `start_ball` level.
  - Required: no state or score change; no repeated serve from the held level.
  - Then `reset` asserted mid-SERVE returns everything to reset values on the next edge.
